dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipelined core's data port (M stage). Serves
//  loads/stores on the core's {mem_writeM, mem_sizeM, alu_outM, write_dataM,
//  read_dataM} interface: word RAM with byte lanes, RV32 load extension, and an
//  MMIO window (console TX FIFO, halt/exit register, cycle counter).
// PARAMETERS
//  ADDR_W     12            word-address bits; RAM depth = 2**ADDR_W words
//  MMIO_BASE  32'hFFFF_0000 first MMIO byte address; addr >= MMIO_BASE is MMIO
//  FIFO_DEPTH 8             console FIFO entries, power of 2, >= 2
// PORTS
//  clk            in   1   clock, rising edge
//  reset_n        in   1   asynchronous reset, active low
//  mem_writeM     in   1   store strobe for current M-stage access
//  mem_sizeM      in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  alu_outM       in   32  byte address
//  write_dataM    in   32  store data, right-aligned
//  read_dataM     out  32  load data, extended, combinational from address
//  console_data   out  8   FIFO head byte
//  console_valid  out  1   FIFO non-empty
//  console_ready  in   1   sink accepts head this cycle
//  halt_req       out  1   sticky, set by any store to HALT
//  exit_code      out  32  value of last HALT store
//  misalign       out  1   sticky misaligned-access flag
// BEHAVIOUR
//  Reset (reset_n low, async): console_valid/halt_req/misalign=0, exit_code=0,
//   FIFO empty (pointers, count 0), overflow=0, cycle counter 0. RAM not
//   reset. No writes of any kind while reset_n low.
//  Decode: MMIO if alu_outM >= MMIO_BASE, else RAM word alu_outM[ADDR_W+1:2];
//   upper address bits ignored (aliasing). off = alu_outM[1:0].
//  Loads: combinational, zero latency (core samples same cycle). Lane select
//   word >> 8*off; B/H sign-extend, BU/HU zero-extend, W unchanged. Undefined
//   funct3 (011,110,111) treated as W.
//  Stores: on rising clk when mem_writeM. Byte enables: B 0001<<off, H
//   0011<<off, W 1111; data = write_dataM << 8*off. Read-during-write on same
//   address returns old data (write lands at edge).
//  Misaligned: H with off[0]=1, W with off!=0 -> store suppressed,
//   read_dataM=0, misalign set at next edge (only when mem_writeM or read
//   attempted with mem_sizeM valid); cleared only by reset.
//  MMIO map (word-aligned, offsets from MMIO_BASE):
//   +0x0 CONSOLE W: push write_dataM[7:0]. R: {overflow,14'b0,full,count[15:0]}
//   +0x4 HALT    W: halt_req<=1, exit_code<=write_dataM. R: exit_code
//   +0x8 CYCLE   R: free-running 32-bit counter, +1 every clk, wraps to 0. W ignored
//   other offsets: R 0, W ignored. MMIO accesses use full word; mem_sizeM ignored.
//  Console FIFO: console_data = head, console_valid = count!=0. Pop when
//   valid&ready at edge. Push when full and no pop -> byte dropped, overflow
//   sticky. Full + push + pop same edge -> both occur, count unchanged.
//   Empty + push + ready -> push only (valid was 0). Pointers wrap mod depth.
//  halt_req does not stop the FIFO, counter, or further accesses.
// TESTING
//  SW 0xDEADBEEF @0x10, then LB/LBU @0x13 -> 0xFFFFFFDE / 0x000000DE
//  SH 0x1234 @0x12 over 0xDEADBEEF -> LW @0x10 = 0x1234BEEF; SB 0x55 @0x11 -> 0x1234 55EF
//  SW @0x12 (misaligned) -> RAM unchanged, read_dataM=0, misalign=1 next cycle
//  9 CONSOLE stores, ready=0, depth 8 -> count 8, full=1, overflow=1; then ready=1
//   -> 8 bytes out in order, valid drops after 8th pop
//  Store 0x2A to HALT -> halt_req=1, exit_code=0x2A; CYCLE reads increase by 1/clk
//  Assert reset_n low mid-stream with FIFO holding 3 bytes -> valid=0 immediately,
//   count 0, flags 0, RAM data written before reset still readable

Source files
------------

// File: rtl/dmem_responder.sv
// Data-port responder for the pipelined core: byte-lane word RAM with RV32 load
// extension, plus an MMIO window for console FIFO, halt/exit and cycle counter.
module dmem_responder #(
  parameter int          ADDR_W     = 12,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_writeM,
  input  logic [2:0]  mem_sizeM,
  input  logic [31:0] alu_outM,
  input  logic [31:0] write_dataM,
  output logic [31:0] read_dataM,
  output logic [7:0]  console_data,
  output logic        console_valid,
  input  logic        console_ready,
  output logic        halt_req,
  output logic [31:0] exit_code,
  output logic        misalign
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [29:0] MMIO_WBASE = MMIO_BASE[31:2];

  logic [31:0] mem [2**ADDR_W];
  logic [7:0]  fifo [FIFO_DEPTH];

  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   cycleCnt;

  logic              isMmio, isByte, isHalf, isWord, signedLd, sizeValid, badAlign;
  logic [1:0]        off;
  logic [29:0]       mmioWord;
  logic [ADDR_W-1:0] wordAddr;
  logic [3:0]        byteEn;
  logic [31:0]       wrData, ramWord, lane, ramRd, mmioRd, status;
  logic              ramWe, consPush, haltWr, full, doPop, doPush;

  assign isMmio   = alu_outM >= MMIO_BASE;
  assign mmioWord = alu_outM[31:2] - MMIO_WBASE;
  assign wordAddr = alu_outM[ADDR_W+1:2];
  assign off      = alu_outM[1:0];

  assign isByte    = (mem_sizeM == 3'b000) || (mem_sizeM == 3'b100);
  assign isHalf    = (mem_sizeM == 3'b001) || (mem_sizeM == 3'b101);
  assign isWord    = !isByte && !isHalf;
  assign signedLd  = !mem_sizeM[2];
  assign sizeValid = isByte || isHalf || (mem_sizeM == 3'b010);
  // MMIO always uses the full word, so alignment only matters for RAM
  assign badAlign  = !isMmio && ((isHalf && off[0]) || (isWord && off != 2'b00));

  always_comb begin
    byteEn = 4'b1111;
    if (isByte)      byteEn = 4'b0001 << off;
    else if (isHalf) byteEn = 4'b0011 << off;
  end

  assign wrData = write_dataM << {off, 3'b000};
  assign ramWe  = mem_writeM && !isMmio && !badAlign;

  // Storage has no reset; writes are held off while reset is asserted
  always_ff @(posedge clk) begin
    if (reset_n && ramWe) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordAddr][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

  assign ramWord = mem[wordAddr];
  assign lane    = ramWord >> {off, 3'b000};

  always_comb begin
    ramRd = lane;
    if (isByte)      ramRd = signedLd ? {{24{lane[7]}}, lane[7:0]}  : {24'b0, lane[7:0]};
    else if (isHalf) ramRd = signedLd ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
  end

  assign full   = count == CW'(FIFO_DEPTH);
  assign status = {overflow, 14'b0, full, 16'(count)};

  always_comb begin
    mmioRd = 32'b0;
    case (mmioWord)
      30'd0:   mmioRd = status;
      30'd1:   mmioRd = exit_code;
      30'd2:   mmioRd = cycleCnt;
      default: mmioRd = 32'b0;
    endcase
  end

  assign read_dataM = isMmio ? mmioRd : (badAlign ? 32'b0 : ramRd);

  assign consPush      = mem_writeM && isMmio && (mmioWord == 30'd0);
  assign haltWr        = mem_writeM && isMmio && (mmioWord == 30'd1);
  assign console_valid = count != '0;
  assign console_data  = fifo[rdPtr];
  assign doPop         = console_valid && console_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign doPush        = consPush && (!full || doPop);

  always_ff @(posedge clk) begin
    if (reset_n && doPush) fifo[wrPtr] <= write_dataM[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      cycleCnt  <= 32'b0;
      halt_req  <= 1'b0;
      exit_code <= 32'b0;
      misalign  <= 1'b0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (consPush && !doPush) overflow <= 1'b1;
      if (haltWr) begin
        halt_req  <= 1'b1;
        exit_code <= write_dataM;
      end
      if (badAlign && (mem_writeM || sizeValid)) misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes/extension, misalignment, console
// FIFO corner cases, halt/cycle registers and mid-stream reset.
module tb_dmem_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;
  localparam logic [2:0]  SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                          SZ_BU = 3'b100, SZ_HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_writeM;
  logic [2:0]  mem_sizeM;
  logic [31:0] alu_outM, write_dataM, read_dataM;
  logic [7:0]  console_data;
  logic        console_valid, console_ready, halt_req, misalign;
  logic [31:0] exit_code;
  logic [31:0] tbCyc;
  int          numChecks = 0;
  int          numErrs = 0;
  logic [7:0]  expBytes [8];

  dmem_responder dut (
    .clk(clk), .reset_n(reset_n), .mem_writeM(mem_writeM), .mem_sizeM(mem_sizeM),
    .alu_outM(alu_outM), .write_dataM(write_dataM), .read_dataM(read_dataM),
    .console_data(console_data), .console_valid(console_valid),
    .console_ready(console_ready), .halt_req(halt_req), .exit_code(exit_code),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Reference cycle counter, independent of the DUT
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tbCyc <= 32'b0;
    else          tbCyc <= tbCyc + 32'd1;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic acc(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    mem_writeM  = we;
    mem_sizeM   = sz;
    alu_outM    = a;
    write_dataM = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    acc(1'b1, sz, a, d);
    step();
    acc(1'b0, SZ_W, 32'h0, 32'h0);
  endtask

  task automatic load(input string tag, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] exp);
    acc(1'b0, sz, a, 32'h0);
    checkVal(tag, read_dataM, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    console_ready = 1'b0;
    acc(1'b0, SZ_W, MB, 32'h0);
    #2;
    checkVal("rst_valid", {31'b0, console_valid}, 32'h0);
    checkVal("rst_halt", {31'b0, halt_req}, 32'h0);
    checkVal("rst_misalign", {31'b0, misalign}, 32'h0);
    checkVal("rst_exit", exit_code, 32'h0);
    checkVal("rst_status", read_dataM, 32'h0);
    load("rst_cycle", SZ_W, MB + 32'h8, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;

    // RAM word store and load extension
    store(SZ_W, 32'h10, 32'hDEADBEEF);
    load("lw_10", SZ_W, 32'h10, 32'hDEADBEEF);
    load("lb_13", SZ_B, 32'h13, 32'hFFFFFFDE);
    load("lbu_13", SZ_BU, 32'h13, 32'h000000DE);
    load("lh_12", SZ_H, 32'h12, 32'hFFFFDEAD);
    load("lhu_10", SZ_HU, 32'h10, 32'h0000BEEF);
    load("undef_w", 3'b011, 32'h10, 32'hDEADBEEF);

    // Read-during-write returns old data
    store(SZ_W, 32'h20, 32'hA5A5A5A5);
    acc(1'b1, SZ_W, 32'h20, 32'h5A5A5A5A);
    checkVal("rdw_old", read_dataM, 32'hA5A5A5A5);
    step();
    load("rdw_new", SZ_W, 32'h20, 32'h5A5A5A5A);

    // Partial stores: upper junk in write data must be masked
    store(SZ_H, 32'h12, 32'hFFFF1234);
    load("sh_12", SZ_W, 32'h10, 32'h1234BEEF);
    store(SZ_B, 32'h11, 32'hAAAAAA55);
    load("sb_11", SZ_W, 32'h10, 32'h123455EF);
    load("alias", SZ_W, 32'h4010, 32'h123455EF);
    checkVal("misalign_pre", {31'b0, misalign}, 32'h0);

    // Misaligned word store is suppressed
    acc(1'b1, SZ_W, 32'h12, 32'hCAFEF00D);
    checkVal("mis_rd0", read_dataM, 32'h0);
    step();
    acc(1'b0, SZ_W, 32'h10, 32'h0);
    checkVal("mis_flag", {31'b0, misalign}, 32'h1);
    checkVal("mis_ram", read_dataM, 32'h123455EF);

    // HALT and CYCLE
    store(SZ_W, MB + 32'h4, 32'h0000002A);
    checkVal("halt_req", {31'b0, halt_req}, 32'h1);
    checkVal("exit_code", exit_code, 32'h2A);
    load("halt_rd", SZ_B, MB + 32'h4, 32'h2A);
    load("cycle_a", SZ_W, MB + 32'h8, tbCyc);
    step();
    load("cycle_b", SZ_W, MB + 32'h8, tbCyc);
    step(); step();
    load("cycle_c", SZ_W, MB + 32'h8, tbCyc);

    // Nine pushes into depth-8 FIFO with sink stalled
    for (int i = 0; i < 9; i++) store(SZ_W, MB, 32'h10 + i);
    load("cons_full", SZ_W, MB, 32'h80010008);
    checkVal("cons_head", {24'b0, console_data}, 32'h10);
    console_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkVal($sformatf("drain_v%0d", i), {31'b0, console_valid}, 32'h1);
      checkVal($sformatf("drain_d%0d", i), {24'b0, console_data}, 32'h10 + i);
      step();
    end
    checkVal("drain_empty", {31'b0, console_valid}, 32'h0);
    load("cons_after", SZ_W, MB, 32'h80000000);

    // Empty + push + ready: push only
    acc(1'b1, SZ_W, MB, 32'h77);
    checkVal("ep_valid0", {31'b0, console_valid}, 32'h0);
    step();
    acc(1'b0, SZ_W, 32'h0, 32'h0);
    checkVal("ep_valid1", {31'b0, console_valid}, 32'h1);
    checkVal("ep_data", {24'b0, console_data}, 32'h77);
    step();
    checkVal("ep_popped", {31'b0, console_valid}, 32'h0);

    // Full + push + pop on the same edge
    console_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(SZ_W, MB, 32'h20 + i);
    acc(1'b1, SZ_W, MB, 32'h99);
    console_ready = 1'b1;
    step();
    acc(1'b0, SZ_W, MB, 32'h0);
    checkVal("fpp_status", read_dataM, 32'h80010008);
    for (int i = 0; i < 7; i++) expBytes[i] = 8'h21 + 8'(i);
    expBytes[7] = 8'h99;
    for (int i = 0; i < 8; i++) begin
      checkVal($sformatf("fpp_d%0d", i), {24'b0, console_data}, {24'b0, expBytes[i]});
      step();
    end
    checkVal("fpp_empty", {31'b0, console_valid}, 32'h0);

    // Reset in the middle of traffic
    console_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(SZ_W, MB, 32'h31 + i);
    load("pre_rst_cnt", SZ_W, MB, 32'h80000003);
    reset_n = 1'b0;
    #1;
    checkVal("mr_valid", {31'b0, console_valid}, 32'h0);
    checkVal("mr_halt", {31'b0, halt_req}, 32'h0);
    checkVal("mr_misalign", {31'b0, misalign}, 32'h0);
    checkVal("mr_exit", exit_code, 32'h0);
    checkVal("mr_status", read_dataM, 32'h0);
    acc(1'b1, SZ_W, 32'h10, 32'hBAD0BAD0);
    step(); step();
    acc(1'b0, SZ_W, 32'h10, 32'h0);
    reset_n = 1'b1;
    #1;
    checkVal("mr_ram", read_dataM, 32'h123455EF);
    load("mr_cycle", SZ_W, MB + 32'h8, tbCyc);

    $display("Result: errors=%0d of %0d checks", numErrs, numChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
